// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Two-port write-back arbiter in front of a register-file write port.
//   Port A (ALU) and port B (load unit) each present valid/rd/wd. One
//   request is accepted per cycle. A contended cycle goes to the port
//   that did not win the previous acceptance. The accepted request is
//   registered onto rf_we/rf_rd/rf_wd for exactly one cycle. Writes to
//   register 0 are accepted but never drive rf_we.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   hold       in   write-back stall, blocks all acceptance
//   a_valid    in   ALU request valid
//   a_rd       in   ALU destination index [4:0]
//   a_wd       in   ALU write data [DW-1:0]
//   a_ready    out  ALU request accepted this cycle (combinational)
//   b_valid    in   load-unit request valid
//   b_rd       in   load-unit destination index [4:0]
//   b_wd       in   load-unit write data [DW-1:0]
//   b_ready    out  load-unit request accepted this cycle (combinational)
//   rf_we      out  register-file write enable (registered)
//   rf_rd      out  register-file destination index (registered)
//   rf_wd      out  register-file write data (registered)
//   conflicts  out  saturating count of contended cycles
module regfile_wb_arbiter #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          a_valid,
  input  logic [4:0]    a_rd,
  input  logic [DW-1:0] a_wd,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [4:0]    b_rd,
  input  logic [DW-1:0] b_wd,
  output logic          b_ready,
  output logic          rf_we,
  output logic [4:0]    rf_rd,
  output logic [DW-1:0] rf_wd,
  output logic [7:0]    conflicts
);

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  logic          r_last_grant;
  logic          r_rf_we;
  logic [4:0]    r_rf_rd;
  logic [DW-1:0] r_rf_wd;
  logic [7:0]    r_conflicts;

  logic          w_a_ready;
  logic          w_b_ready;
  logic          w_accept;
  logic          w_contend;
  logic [4:0]    w_sel_rd;
  logic [DW-1:0] w_sel_wd;

  // Grant decision: readies are forced low during reset or stall; a lone
  // request always wins, a contended cycle goes to the port not granted last.
  always_comb begin
    w_a_ready = 1'b0;
    w_b_ready = 1'b0;
    if (rst || hold) begin
      w_a_ready = 1'b0;
      w_b_ready = 1'b0;
    end else if (a_valid && b_valid) begin
      if (r_last_grant == GRANT_B) begin
        w_a_ready = 1'b1;
      end else begin
        w_b_ready = 1'b1;
      end
    end else begin
      w_a_ready = a_valid;
      w_b_ready = b_valid;
    end
  end

  // Select the winning request's payload; only meaningful when w_accept=1.
  always_comb begin
    w_sel_rd = b_rd;
    w_sel_wd = b_wd;
    if (w_a_ready) begin
      w_sel_rd = a_rd;
      w_sel_wd = a_wd;
    end else begin
      w_sel_rd = b_rd;
      w_sel_wd = b_wd;
    end
  end

  assign w_accept  = w_a_ready | w_b_ready;
  assign w_contend = a_valid & b_valid & ~hold;

  // Priority memory: records the most recent acceptance. Resetting to B
  // makes the first contended cycle after reset go to A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= GRANT_B;
    end else if (w_accept) begin
      r_last_grant <= w_a_ready ? GRANT_A : GRANT_B;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

  // Register-file issue stage: one-cycle write pulse per acceptance; index
  // and data hold their last values when nothing is accepted. Register 0 is
  // hardwired, so its writes are accepted but suppressed here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rf_we <= 1'b0;
      r_rf_rd <= 5'd0;
      r_rf_wd <= '0;
    end else if (w_accept) begin
      r_rf_we <= (w_sel_rd != 5'd0);
      r_rf_rd <= w_sel_rd;
      r_rf_wd <= w_sel_wd;
    end else begin
      r_rf_we <= 1'b0;
      r_rf_rd <= r_rf_rd;
      r_rf_wd <= r_rf_wd;
    end
  end

  // Contention counter: counts unstalled cycles with both ports requesting,
  // sticking at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conflicts <= 8'd0;
    end else if (w_contend && (r_conflicts != 8'd255)) begin
      r_conflicts <= r_conflicts + 8'd1;
    end else begin
      r_conflicts <= r_conflicts;
    end
  end

  assign a_ready   = w_a_ready;
  assign b_ready   = w_b_ready;
  assign rf_we     = r_rf_we;
  assign rf_rd     = r_rf_rd;
  assign rf_wd     = r_rf_wd;
  assign conflicts = r_conflicts;

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: DW, default 32, data width of the write-back path and register file.
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: hold  input  1  write-back stall; when 1, no request is accepted.
REQ-005 Port: a_valid  input  1  ALU write-back request valid.
REQ-006 Port: a_rd  input  5  ALU destination register index.
REQ-007 Port: a_wd  input  DW  ALU write data.
REQ-008 Port: a_ready  output  1  ALU request accepted this cycle.
REQ-009 Port: b_valid  input  1  load-unit write-back request valid.
REQ-010 Port: b_rd  input  5  load-unit destination register index.
REQ-011 Port: b_wd  input  DW  load-unit write data.
REQ-012 Port: b_ready  output  1  load-unit request accepted this cycle.
REQ-013 Port: rf_we  output  1  register-file write enable, registered.
REQ-014 Port: rf_rd  output  5  register-file destination index, registered.
REQ-015 Port: rf_wd  output  DW  register-file write data, registered.
REQ-016 Port: conflicts  output  8  saturating count of contention cycles.

Function
REQ-017 A request SHALL be accepted in a cycle when its valid and ready are both 1 at the rising edge.
REQ-018 a_ready and b_ready SHALL be combinational, SHALL never both be 1, and SHALL both be 0 while hold=1 or rst=1.
REQ-019 With only one valid asserted and hold=0, that port's ready SHALL be 1 regardless of priority state.
REQ-020 With both valid and hold=0, grant SHALL go to the port not recorded in last_grant, a 1-bit register.
REQ-021 last_grant SHALL update to the accepted port on every acceptance and SHALL hold otherwise, including while hold=1.
REQ-022 An accepted request SHALL appear on rf_rd/rf_wd the cycle after acceptance; rf_we SHALL be 1 for exactly that one cycle.
REQ-023 rf_we SHALL be 0 in any cycle following a cycle with no acceptance; rf_rd/rf_wd SHALL hold their last values then.
REQ-024 A request with rd=0 SHALL be accepted normally (ready, last_grant update), but rf_we SHALL stay 0 for it.
REQ-025 Back-to-back acceptances SHALL produce back-to-back rf_we pulses in acceptance order, with no bubble.
REQ-026 A stalled port SHALL keep its valid, rd and wd stable until accepted; the block SHALL NOT buffer unaccepted requests.
REQ-027 conflicts SHALL increment by 1 on each cycle with a_valid=1, b_valid=1, hold=0; it SHALL saturate at 255.
REQ-028 A request accepted in the cycle before hold rises SHALL still issue on rf_* in the next cycle.

Reset
REQ-029 While rst=1: rf_we=0, rf_rd=0, rf_wd=0, conflicts=0, last_grant=B, asynchronously, without waiting for clk.
REQ-030 Reset asserted between acceptance and issue SHALL cancel that write (rf_we stays 0), and the write SHALL NOT reappear after release.
REQ-031 First contention after reset SHALL be granted to port A.

Verification
REQ-032 Single ALU write: a_valid=1, a_rd=5, a_wd=0xDEADBEEF for one cycle -> a_ready=1 that cycle; next cycle rf_we=1, rf_rd=5, rf_wd=0xDEADBEEF; following cycle rf_we=0.
REQ-033 Contention: a_valid=b_valid=1 held, rd 3/7, after reset -> grants A,B,A,B on consecutive cycles; rf_rd sequence 3,7,3,7 with rf_we=1 every cycle; conflicts counts 4.
REQ-034 x0 drop: b_valid=1, b_rd=0, b_wd=0x1234 -> b_ready=1; next cycle rf_we=0; the next contention is granted to A.
REQ-035 Hold: both valid, hold=1 for 3 cycles -> both ready=0, rf_we=0 during those cycles, conflicts unchanged; after hold=0, the previously due port is granted.
REQ-036 Saturation and reset: contention held 300 cycles -> conflicts=255; rst pulsed mid-cycle after acceptance -> rf_we=0 immediately and conflicts=0 with no clk edge; first grant after release goes to A.
